// File: rtl/score_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : score_sched_pkg
//  Description : Shared types and width helpers for the point-score frame
//                scheduler (FSM state encoding, derived widths).
//  Contents    : state_e            - scheduler FSM states
//                score_w(width)     - score width   = width + 13
//                pt_w(width)        - point vector  = width * 9
//                cnt_w(n_max)       - frame counter = clog2(n_max + 1)
//  Revision    : 1.0 - initial release
// ============================================================================
package score_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_SCORE_W = DEF_WIDTH + 13;
    localparam int DEF_PT_W    = DEF_WIDTH * 9;

    function automatic int score_w(input int width);
        return width + 13;
    endfunction

    function automatic int pt_w(input int width);
        return width * 9;
    endfunction

    // Counter must hold the value n_max itself, hence n_max + 1 states.
    function automatic int cnt_w(input int n_max);
        return $clog2(n_max + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/score_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : score_tag_pipe
//  Description : LAT-deep shift register carrying {valid, id} tags alongside
//                the fixed-latency score unit. Cleared asynchronously on rst.
//  Ports       : clk, rst          clock / async active-high reset
//                tag_valid_i/id_i  tag entering the line
//                tag_valid_o/id_o  tag leaving the line LAT cycles later
//  Revision    : 1.0 - initial release
// ============================================================================
module score_tag_pipe #(
    parameter int LAT  = 21,
    parameter int ID_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tag_valid_i,
    input  logic [ID_W-1:0] tag_id_i,
    output logic            tag_valid_o,
    output logic [ID_W-1:0] tag_id_o
);

    logic            valid_q [LAT];
    logic [ID_W-1:0] id_q    [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                valid_q[i] <= 1'b0;
                id_q[i]    <= '0;
            end
        end else begin
            valid_q[0] <= tag_valid_i;
            id_q[0]    <= tag_id_i;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                id_q[i]    <= id_q[i-1];
            end
        end
    end

    assign tag_valid_o = valid_q[LAT-1];
    assign tag_id_o    = id_q[LAT-1];

endmodule
`default_nettype wire

// File: rtl/score_sched.sv
`default_nettype none
// ============================================================================
//  Module      : score_sched
//  Description : Frame scheduler for the point-score pipeline. Accepts N
//                candidates over valid/ready, issues one per cycle into the
//                fixed-latency score unit, tracks in-flight IDs with a tag
//                delay line, retires returned scores and reports the argmax
//                (best score / ID) at frame end.
//  Ports       : clk, rst               clock / async active-high reset
//                start_i, num_cand_i    frame start and candidate count
//                cand_valid_i/ready_o   candidate handshake
//                cand_point_i, cand_id_i candidate payload
//                sc_point_val_o         registered drive to score unit
//                sc_score_i             score unit result
//                busy_o, done_o         frame status
//                best_score_o, best_id_o argmax of last frame
//                min_score_i, found_o   threshold option only
//  Option      : SCORE_SCHED_THRESH_EN - adds min_score_i / found_o; only
//                scores >= min_score may become best.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_sched
    import score_sched_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int LAT        = 21,
    parameter  int N_CAND_MAX = 256,
    parameter  int ID_W       = 8,
    localparam int CNT_W      = cnt_w(N_CAND_MAX),
    localparam int SCORE_W    = score_w(WIDTH),
    localparam int PT_W       = pt_w(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   num_cand_i,
    input  logic               cand_valid_i,
    output logic               cand_ready_o,
    input  logic [PT_W-1:0]    cand_point_i,
    input  logic [ID_W-1:0]    cand_id_i,
    output logic [PT_W-1:0]    sc_point_val_o,
    input  logic [SCORE_W-1:0] sc_score_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [SCORE_W-1:0] best_score_o,
    output logic [ID_W-1:0]    best_id_o
`ifdef SCORE_SCHED_THRESH_EN
   ,input  logic [SCORE_W-1:0] min_score_i,
    output logic               found_o
`endif
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     num_q, num_d;
    logic [CNT_W-1:0]     issued_q, issued_d;
    logic [CNT_W-1:0]     retired_q, retired_d;
    logic [PT_W-1:0]      pt_q, pt_d;
    logic                 iss_vld_q, iss_vld_d;
    logic [ID_W-1:0]      iss_id_q, iss_id_d;
    logic [SCORE_W-1:0]   best_score_q, best_score_d;
    logic [ID_W-1:0]      best_id_q, best_id_d;
    logic                 best_valid_q, best_valid_d;
    logic                 done_q, done_d;

    logic                 ret_valid;
    logic [ID_W-1:0]      ret_id;
    logic                 qualify;

`ifdef SCORE_SCHED_THRESH_EN
    logic [SCORE_W-1:0]   min_q, min_d;
    logic                 found_q, found_d;
    assign qualify = (sc_score_i >= min_q);
`else
    assign qualify = 1'b1;
`endif

    // The issue tag is registered together with sc_point_val, so the LAT-deep
    // line behind it delivers the tag exactly when the matching score appears.
    score_tag_pipe #(
        .LAT  (LAT),
        .ID_W (ID_W)
    ) u_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .tag_valid_i (iss_vld_q),
        .tag_id_i    (iss_id_q),
        .tag_valid_o (ret_valid),
        .tag_id_o    (ret_id)
    );

    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        issued_d     = issued_q;
        retired_d    = retired_q;
        pt_d         = pt_q;
        iss_vld_d    = 1'b0;
        iss_id_d     = iss_id_q;
        best_score_d = best_score_q;
        best_id_d    = best_id_q;
        best_valid_d = best_valid_q;
        done_d       = 1'b0;
`ifdef SCORE_SCHED_THRESH_EN
        min_d        = min_q;
        found_d      = found_q;
`endif

        // Retire: strict '>' keeps the earlier candidate on ties.
        if (ret_valid) begin
            retired_d = retired_q + CNT_W'(1);
            if (qualify && (!best_valid_q || (sc_score_i > best_score_q))) begin
                best_score_d = sc_score_i;
                best_id_d    = ret_id;
                best_valid_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    best_score_d = '0;
                    best_id_d    = '0;
                    best_valid_d = 1'b0;
`ifdef SCORE_SCHED_THRESH_EN
                    min_d        = min_score_i;
                    found_d      = 1'b0;
`endif
                    if (num_cand_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = ISSUE;
                        num_d     = num_cand_i;
                        issued_d  = '0;
                        retired_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (cand_valid_i) begin
                    pt_d      = cand_point_i;
                    iss_vld_d = 1'b1;
                    iss_id_d  = cand_id_i;
                    issued_d  = issued_q + CNT_W'(1);
                    if (issued_q == (num_q - CNT_W'(1))) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // retired_d already counts a retire happening this cycle.
                if (retired_d == num_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
`ifdef SCORE_SCHED_THRESH_EN
                    found_d = best_valid_d;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            num_q        <= '0;
            issued_q     <= '0;
            retired_q    <= '0;
            pt_q         <= '0;
            iss_vld_q    <= 1'b0;
            iss_id_q     <= '0;
            best_score_q <= '0;
            best_id_q    <= '0;
            best_valid_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef SCORE_SCHED_THRESH_EN
            min_q        <= '0;
            found_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            issued_q     <= issued_d;
            retired_q    <= retired_d;
            pt_q         <= pt_d;
            iss_vld_q    <= iss_vld_d;
            iss_id_q     <= iss_id_d;
            best_score_q <= best_score_d;
            best_id_q    <= best_id_d;
            best_valid_q <= best_valid_d;
            done_q       <= done_d;
`ifdef SCORE_SCHED_THRESH_EN
            min_q        <= min_d;
            found_q      <= found_d;
`endif
        end
    end

    assign cand_ready_o   = (state_q == ISSUE);
    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_q;
    assign sc_point_val_o = pt_q;
    assign best_score_o   = best_score_q;
    assign best_id_o      = best_id_q;
`ifdef SCORE_SCHED_THRESH_EN
    assign found_o        = found_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_score_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_sched
//  Description : Directed self-checking bench for score_sched. The score unit
//                is modelled as a LAT-cycle delay of a lookup on the point
//                vector (score = low SCORE_W bits of the vector).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_sched;

    localparam int WIDTH = 8;
    localparam int LAT   = 21;
    localparam int NMAX  = 256;
    localparam int ID_W  = 8;
    localparam int CNT_W = 9;
    localparam int SW    = 21;
    localparam int PW    = 72;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  num_cand;
    logic              cand_valid;
    logic              cand_ready;
    logic [PW-1:0]     cand_point;
    logic [ID_W-1:0]   cand_id;
    logic [PW-1:0]     sc_point_val;
    logic [SW-1:0]     sc_score;
    logic              busy;
    logic              done;
    logic [SW-1:0]     best_score;
    logic [ID_W-1:0]   best_id;
`ifdef SCORE_SCHED_THRESH_EN
    logic [SW-1:0]     min_score;
    logic              found;
`endif

    score_sched #(
        .WIDTH      (WIDTH),
        .LAT        (LAT),
        .N_CAND_MAX (NMAX),
        .ID_W       (ID_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .num_cand_i     (num_cand),
        .cand_valid_i   (cand_valid),
        .cand_ready_o   (cand_ready),
        .cand_point_i   (cand_point),
        .cand_id_i      (cand_id),
        .sc_point_val_o (sc_point_val),
        .sc_score_i     (sc_score),
        .busy_o         (busy),
        .done_o         (done),
        .best_score_o   (best_score),
        .best_id_o      (best_id)
`ifdef SCORE_SCHED_THRESH_EN
       ,.min_score_i    (min_score),
        .found_o        (found)
`endif
    );

    always #5 clk = ~clk;

    // Score unit model: value seen on sc_score during cycle c is the lookup
    // of sc_point_val during cycle c-LAT. Not reset, like the real unit.
    logic [PW-1:0] pv_hist [LAT];
    always @(posedge clk) begin
        pv_hist[0] <= sc_point_val;
        for (int i = 1; i < LAT; i++) pv_hist[i] <= pv_hist[i-1];
    end
    assign sc_score = pv_hist[LAT-1][SW-1:0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int last_hs  = 0;
    logic saw_done;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [SW-1:0] sc, input logic [ID_W-1:0] id);
        int n;
        n          = 0;
        cand_valid = 1'b1;
        cand_point = {51'(id) + 51'h1234, sc};
        cand_id    = id;
        while (!cand_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", PW'(cand_ready), PW'(1));
        last_hs = cyc;
        tick();
        cand_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc, input string tag);
        int n;
        n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, PW'(done), PW'(1));
        chk({tag, "_cyc"}, PW'(cyc), PW'(exp_cyc));
    endtask

    task automatic start_frame(input int n);
        start    = 1'b1;
        num_cand = CNT_W'(n);
        tick();
        start    = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) pv_hist[i] = '0;
        rst        = 1'b1;
        start      = 1'b0;
        num_cand   = '0;
        cand_valid = 1'b0;
        cand_point = '0;
        cand_id    = '0;
`ifdef SCORE_SCHED_THRESH_EN
        min_score  = '0;
`endif
        tick();
        tick();
        // Reset state
        chk("rst_busy",  PW'(busy), PW'(0));
        chk("rst_done",  PW'(done), PW'(0));
        chk("rst_ready", PW'(cand_ready), PW'(0));
        chk("rst_best",  PW'(best_score), PW'(0));
        chk("rst_id",    PW'(best_id), PW'(0));
        chk("rst_pt",    sc_point_val, PW'(0));
`ifdef SCORE_SCHED_THRESH_EN
        chk("rst_found", PW'(found), PW'(0));
`endif
        rst = 1'b0;
        tick();

        // 1: four back-to-back candidates, tie on 300 keeps id 1
        start_frame(4);
        chk("t1_ready", PW'(cand_ready), PW'(1));
        chk("t1_busy",  PW'(busy), PW'(1));
        send(21'd100, 8'd0);
        send(21'd300, 8'd1);
        send(21'd200, 8'd2);
        send(21'd300, 8'd3);
        chk("t1_ready_off", PW'(cand_ready), PW'(0));
        wait_done(last_hs + 2 + LAT, "t1");
        chk("t1_best", PW'(best_score), PW'(300));
        chk("t1_id",   PW'(best_id), PW'(1));
        chk("t1_busy_done", PW'(busy), PW'(1));
        tick();
        chk("t1_done_pulse", PW'(done), PW'(0));
        chk("t1_idle", PW'(busy), PW'(0));
        chk("t1_hold", PW'(best_score), PW'(300));

        // 2: same frame with gaps 1,0,0,1,1,0,1
        start_frame(4);
        send(21'd100, 8'd0);
        tick();
        tick();
        send(21'd300, 8'd1);
        send(21'd200, 8'd2);
        tick();
        send(21'd300, 8'd3);
        wait_done(last_hs + 2 + LAT, "t2");
        chk("t2_best",    PW'(best_score), PW'(300));
        chk("t2_id",      PW'(best_id), PW'(1));
        chk("t2_retired", PW'(dut.retired_q), PW'(4));
        tick();

        // 3: empty frame
        start_frame(0);
        chk("t3_done", PW'(done), PW'(1));
        chk("t3_busy", PW'(busy), PW'(0));
        chk("t3_best", PW'(best_score), PW'(0));
        chk("t3_id",   PW'(best_id), PW'(0));
        tick();
        chk("t3_done_pulse", PW'(done), PW'(0));

        // 4: reset in DRAIN with two high scores in flight
        start_frame(2);
        send(21'd900, 8'd5);
        send(21'd800, 8'd6);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t4_busy", PW'(busy), PW'(0));
        chk("t4_pt",   sc_point_val, PW'(0));
        chk("t4_ready", PW'(cand_ready), PW'(0));
        saw_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        chk("t4_no_done", PW'(saw_done), PW'(0));
        start_frame(1);
        send(21'd50, 8'd9);
        wait_done(last_hs + 2 + LAT, "t4");
        chk("t4_best", PW'(best_score), PW'(50));
        chk("t4_id",   PW'(best_id), PW'(9));
        tick();

        // 5: start during ISSUE is ignored
        start_frame(3);
        send(21'd10, 8'd0);
        start    = 1'b1;
        num_cand = CNT_W'(9);
        send(21'd20, 8'd1);
        start    = 1'b0;
        send(21'd30, 8'd2);
        chk("t5_ready_off", PW'(cand_ready), PW'(0));
        wait_done(last_hs + 2 + LAT, "t5");
        chk("t5_best", PW'(best_score), PW'(30));
        chk("t5_id",   PW'(best_id), PW'(2));
        tick();

`ifdef SCORE_SCHED_THRESH_EN
        // 6: threshold 250
        min_score = 21'd250;
        start_frame(2);
        send(21'd100, 8'd0);
        send(21'd200, 8'd1);
        wait_done(last_hs + 2 + LAT, "t6a");
        chk("t6a_found", PW'(found), PW'(0));
        chk("t6a_best",  PW'(best_score), PW'(0));
        chk("t6a_id",    PW'(best_id), PW'(0));
        tick();
        start_frame(2);
        send(21'd100, 8'd0);
        send(21'd260, 8'd1);
        wait_done(last_hs + 2 + LAT, "t6b");
        chk("t6b_found", PW'(found), PW'(1));
        chk("t6b_best",  PW'(best_score), PW'(260));
        chk("t6b_id",    PW'(best_id), PW'(1));
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
